rf_writeback_arbiter: RTL and testbench

- Writer-side companion to the register file: the single owner of the register file's write port (we, wr_address, wr_value).
- Merges two result sources: single-cycle ALU results, and variable-latency load results arriving over a valid/ready handshake.
- Load results are buffered in a small FIFO. At most one register write is issued per cycle, with a bounded-starvation guarantee for loads.
- Exports a pending-write mask so the hazard logic can stall readers of registers with queued load writes.

---
 rtl/rf_writeback_arbiter.sv | 133 +++++++++++++
 tb/tb_rf_writeback_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_arbiter.sv
// Sole owner of the register-file write port: merges single-cycle ALU results with
// FIFO-buffered load results, one write per cycle, with a bounded-starvation drain for loads.
module rf_writeback_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_value,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_value,
  output logic            we,
  output logic [4:0]      wr_address,
  output logic [XLEN-1:0] wr_value,
  output logic            alu_stall,
  output logic [31:0]     pending_mask,
  output logic            err_overrun
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [4:0]      fifo_rd    [DEPTH];
  logic [XLEN-1:0] fifo_value [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [3:0]      starve;

  logic            nonempty;
  logic            push;
  logic            pop;
  logic            alu_win;
  logic            issue;
  logic            starve_hit;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_value;

  assign nonempty = (count != '0);
  assign ld_ready = (count != CW'(DEPTH));
  // x0 loads complete the handshake but never occupy an entry
  assign push     = ld_valid && ld_ready && (ld_rd != 5'd0);

  always_comb begin
    pop       = 1'b0;
    alu_win   = 1'b0;
    issue     = 1'b0;
    sel_rd    = fifo_rd[head];
    sel_value = fifo_value[head];
    if (alu_stall && nonempty) begin
      pop   = 1'b1;
      issue = 1'b1;
    end else if (alu_valid) begin
      alu_win   = 1'b1;
      issue     = (alu_rd != 5'd0);
      sel_rd    = alu_rd;
      sel_value = alu_value;
    end else if (nonempty) begin
      pop   = 1'b1;
      issue = 1'b1;
    end
  end

  // Counter saturating at STARVE_LIMIT arms a one-cycle ALU stall for the next cycle
  assign starve_hit = alu_win && nonempty && (starve == 4'(STARVE_LIMIT - 1));

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] offset;
      offset = PW'(i) - head;
      if ({1'b0, offset} < count) begin
        pending_mask[fifo_rd[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[tail]    <= ld_rd;
      fifo_value[tail] <= ld_value;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      starve      <= '0;
      alu_stall   <= 1'b0;
      we          <= 1'b0;
      wr_address  <= '0;
      wr_value    <= '0;
      err_overrun <= 1'b0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      we <= issue;
      if (issue) begin
        wr_address <= sel_rd;
        wr_value   <= sel_value;
      end

      if (alu_stall && alu_valid) begin
        err_overrun <= 1'b1;
      end

      alu_stall <= starve_hit;
      if (pop || !nonempty) begin
        starve <= '0;
      end else if (alu_win) begin
        starve <= starve_hit ? '0 : starve + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Randomized and directed bench for rf_writeback_arbiter against a queue-based reference model.
module tb_rf_writeback_arbiter;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 3;

  logic            clk;
  logic            reset;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_value;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_value;
  logic            we;
  logic [4:0]      wr_address;
  logic [XLEN-1:0] wr_value;
  logic            alu_stall;
  logic [31:0]     pending_mask;
  logic            err_overrun;

  int errors = 0;
  int checks = 0;

  rf_writeback_arbiter #(
    .XLEN(XLEN),
    .DEPTH(DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .alu_valid(alu_valid),
    .alu_rd(alu_rd),
    .alu_value(alu_value),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_rd(ld_rd),
    .ld_value(ld_value),
    .we(we),
    .wr_address(wr_address),
    .wr_value(wr_value),
    .alu_stall(alu_stall),
    .pending_mask(pending_mask),
    .err_overrun(err_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: loads live in a plain queue in acceptance order
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] val;
  } ent_t;

  ent_t            q[$];
  bit              started = 0;
  bit              m_we;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_val;
  bit              m_stall;
  bit              m_err;
  int              starve;

  always @(posedge clk) begin
    int  n;
    bit  do_pop;
    bit  alu_won;
    bit  can_take;
    if (!reset) begin
      q.delete();
      m_we = 0; m_addr = '0; m_val = '0; m_stall = 0; m_err = 0; starve = 0;
      started = 1;
    end else if (started) begin
      n        = q.size();
      can_take = (n != DEPTH);
      do_pop   = 0;
      alu_won  = 0;
      if (m_stall && alu_valid) m_err = 1;
      m_we = 0;
      if (m_stall && n > 0) do_pop = 1;
      else if (alu_valid) begin
        alu_won = 1;
        if (alu_rd != 0) begin
          m_we = 1; m_addr = alu_rd; m_val = alu_value;
        end
      end else if (n > 0) do_pop = 1;
      if (do_pop) begin
        m_we = 1; m_addr = q[0].rd; m_val = q[0].val;
        void'(q.pop_front());
      end
      m_stall = 0;
      if (do_pop || n == 0) starve = 0;
      else if (alu_won) begin
        starve++;
        if (starve == LIMIT) begin
          m_stall = 1;
          starve  = 0;
        end
      end
      if (can_take && ld_valid && ld_rd != 0) q.push_back('{rd: ld_rd, val: ld_value});
    end
  end

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) m[q[i].rd] = 1'b1;
    return m;
  endfunction

  always @(negedge clk) begin
    if (started) begin
      chk("we", we, m_we);
      if (m_we) begin
        chk("wr_address", wr_address, m_addr);
        chk("wr_value", wr_value, m_val);
      end
      chk("alu_stall", alu_stall, m_stall);
      chk("err_overrun", err_overrun, m_err);
      chk("ld_ready", ld_ready, (q.size() != DEPTH));
      chk("pending_mask", pending_mask, model_mask());
    end
  end

  task automatic idle();
    alu_valid = 0; alu_rd = '0; alu_value = '0;
    ld_valid  = 0; ld_rd  = '0; ld_value  = '0;
  endtask

  task automatic rand_traffic();
    alu_valid = 1'($urandom_range(0, 1)); alu_rd = 5'($urandom); alu_value = $urandom;
    ld_valid  = 1'($urandom_range(0, 1)); ld_rd  = 5'($urandom); ld_value  = $urandom;
  endtask

  task automatic reset_with_traffic();
    reset = 0;
    rand_traffic();
    @(negedge clk);
    rand_traffic();
    @(negedge clk);
    reset = 1;
    idle();
    chk("rst_we", we, 0);
    chk("rst_addr", wr_address, 0);
    chk("rst_ready", ld_ready, 1);
    chk("rst_mask", pending_mask, 0);
    chk("rst_err", err_overrun, 0);
    chk("rst_stall", alu_stall, 0);
    @(negedge clk);
    chk("post_rst_we", we, 0);
  endtask

  initial begin
    reset = 0;
    rand_traffic();
    reset_with_traffic();

    // ALU only
    alu_valid = 1; alu_rd = 5; alu_value = 32'hDEADBEEF;
    @(negedge clk);
    chk("alu_we", we, 1);
    chk("alu_addr", wr_address, 5);
    chk("alu_val", wr_value, 32'hDEADBEEF);
    alu_rd = 0; alu_value = 32'h12345678;
    @(negedge clk);
    chk("alu_x0_we", we, 0);
    idle();
    @(negedge clk);

    // Fill under continuous ALU pressure, then drain in order
    alu_valid = 1; alu_rd = 20; alu_value = 32'hA1;
    for (int k = 0; k < 4; k++) begin
      ld_valid = 1; ld_rd = 5'(k + 1); ld_value = 32'h11 * (k + 1);
      @(negedge clk);
    end
    chk("fill_ready", ld_ready, 0);
    chk("fill_mask", pending_mask, 32'h1E);
    chk("fill_stall", alu_stall, 1);
    idle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drain_we", we, 1);
      chk("drain_addr", wr_address, 32'(k + 1));
      chk("drain_val", wr_value, 32'h11 * (k + 1));
    end
    chk("drain_mask", pending_mask, 0);

    // Simultaneous load and ALU
    ld_valid = 1; ld_rd = 7; ld_value = 32'h77;
    @(negedge clk);
    chk("sim_mask7", pending_mask, 32'h80);
    chk("sim_we0", we, 0);
    idle();
    alu_valid = 1; alu_rd = 8; alu_value = 32'h88;
    @(negedge clk);
    chk("sim_alu_addr", wr_address, 8);
    chk("sim_mask_held", pending_mask, 32'h80);
    idle();
    @(negedge clk);
    chk("sim_ld_addr", wr_address, 7);
    chk("sim_ld_val", wr_value, 32'h77);
    chk("sim_mask_clr", pending_mask, 0);

    // Overrun: ALU asserted during the stall cycle
    alu_valid = 1; alu_rd = 10; alu_value = 32'hA0;
    ld_valid = 1; ld_rd = 3; ld_value = 32'h33;
    @(negedge clk);
    ld_valid = 0;
    repeat (3) @(negedge clk);
    chk("ovr_stall", alu_stall, 1);
    alu_rd = 11; alu_value = 32'hBAD;
    @(negedge clk);
    chk("ovr_addr", wr_address, 3);
    chk("ovr_val", wr_value, 32'h33);
    chk("ovr_err", err_overrun, 1);
    idle();
    repeat (3) @(negedge clk);
    chk("ovr_sticky", err_overrun, 1);
    reset_with_traffic();

    // x0 load is accepted but not queued
    ld_valid = 1; ld_rd = 0; ld_value = 32'hFFFF;
    @(negedge clk);
    chk("x0_mask", pending_mask, 0);
    chk("x0_ready", ld_ready, 1);
    idle();
    @(negedge clk);
    chk("x0_we", we, 0);

    // Randomized traffic at several load/ALU mixes, with occasional mid-run reset
    for (int phase = 0; phase < 4; phase++) begin
      int alu_pct;
      int ld_pct;
      alu_pct = (phase == 0) ? 20 : (phase == 1) ? 50 : (phase == 2) ? 80 : 95;
      ld_pct  = (phase == 0) ? 30 : (phase == 1) ? 60 : (phase == 2) ? 90 : 50;
      for (int c = 0; c < 500; c++) begin
        reset     = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
        alu_valid = ($urandom_range(0, 99) < alu_pct) && !alu_stall;
        alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        alu_value = $urandom;
        ld_valid  = ($urandom_range(0, 99) < ld_pct);
        ld_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ld_value  = $urandom;
        @(negedge clk);
      end
    end
    reset = 1;
    idle();
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
